zeroriscy_ex_seq: RTL and testbench

ZERORISCY_EX_SEQ -- requirements
Module: zeroriscy_ex_seq

---
 rtl/zeroriscy_ex_seq.sv | 150 +++++++++++++++
 tb/tb_zeroriscy_ex_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zeroriscy_ex_seq.sv
// Execute-stage sequencer for multi-cycle functional units.
// Accepts one operation at a time from ID, pulses the chosen unit's start,
// waits for that unit's done (bounded by a timeout), holds the result until
// the register file takes it, then retires. flush_i kills the operation.
module zeroriscy_ex_seq #(
  parameter int NUM_UNITS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64,
  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            issue_valid_i,
  input  logic [UW-1:0]                   issue_unit_i,
  output logic                            issue_ready_o,
  input  logic                            flush_i,
  output logic [NUM_UNITS-1:0]            unit_start_o,
  input  logic [NUM_UNITS-1:0]            unit_done_i,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_result_i,
  output logic                            wb_valid_o,
  output logic [DATA_WIDTH-1:0]           wb_data_o,
  input  logic                            wb_ready_i,
  output logic                            ex_ready_o,
  output logic                            err_o,
  output logic                            busy_o
);

  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int NPOW = 1 << UW;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [UW-1:0]          unit_q, unit_d;
  logic [DATA_WIDTH-1:0]  wb_data_q, wb_data_d;
  logic [NUM_UNITS-1:0]   start_q, start_d;
  logic                   ex_ready_q, ex_ready_d;
  logic                   err_q, err_d;

  logic                   accept;
  logic                   issue_legal;
  logic                   sel_done;
  logic [DATA_WIDTH-1:0]  sel_result;
  logic [NPOW-1:0]        legal_mask;

  // Table of which encodable unit indices actually exist.
  for (genvar i = 0; i < NPOW; i++) begin : g_legal
    assign legal_mask[i] = (i < NUM_UNITS);
  end

  assign issue_ready_o = (state_q == IDLE) & ~flush_i;
  assign accept        = issue_valid_i & issue_ready_o;
  assign issue_legal   = legal_mask[issue_unit_i];

  // Pick the done strobe and result of the latched unit; all other units are ignored.
  always_comb begin
    sel_done   = 1'b0;
    sel_result = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (unit_q == UW'(k)) begin
        sel_done   = unit_done_i[k];
        sel_result = unit_result_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state and registered-output logic; flush has priority over every other event.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    unit_d     = unit_q;
    wb_data_d  = wb_data_q;
    start_d    = '0;
    ex_ready_d = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (issue_legal) begin
            unit_d  = issue_unit_i;
            state_d = EXEC;
            for (int k = 0; k < NUM_UNITS; k++) begin
              start_d[k] = (issue_unit_i == UW'(k));
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      EXEC: begin
        if (flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sel_done) begin
          wb_data_d = sel_result;
          state_d   = HOLD;
          cnt_d     = '0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (wb_ready_i) begin
          state_d    = IDLE;
          ex_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously so a reset drops any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      unit_q     <= '0;
      wb_data_q  <= '0;
      start_q    <= '0;
      ex_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      unit_q     <= unit_d;
      wb_data_q  <= wb_data_d;
      start_q    <= start_d;
      ex_ready_q <= ex_ready_d;
      err_q      <= err_d;
    end
  end

  assign unit_start_o = start_q;
  assign wb_valid_o   = (state_q == HOLD);
  assign wb_data_o    = wb_data_q;
  assign ex_ready_o   = ex_ready_q;
  assign err_o        = err_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_zeroriscy_ex_seq.sv
// Testbench for zeroriscy_ex_seq: a driver issues operations and pushes the
// expected writeback/retire/error events into a queue; a monitor pops and
// compares them whenever the DUT presents one. Per-cycle expectations come
// from a cycle-index model of each operation's outcome.
module tb_zeroriscy_ex_seq;

  localparam int NU = 3;
  localparam int DW = 32;
  localparam int TO = 8;

  localparam int EV_WB   = 0;
  localparam int EV_RET  = 1;
  localparam int EV_ERR  = 2;
  localparam int EV_NONE = 3;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } ev_t;

  logic             clk;
  logic             rst_n;
  logic             issue_valid_i;
  logic [1:0]       issue_unit_i;
  logic             issue_ready_o;
  logic             flush_i;
  logic [NU-1:0]    unit_start_o;
  logic [NU-1:0]    unit_done_i;
  logic [NU*DW-1:0] unit_result_i;
  logic             wb_valid_o;
  logic [DW-1:0]    wb_data_o;
  logic             wb_ready_i;
  logic             ex_ready_o;
  logic             err_o;
  logic             busy_o;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  zeroriscy_ex_seq #(.NUM_UNITS(NU), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid_i(issue_valid_i),
    .issue_unit_i (issue_unit_i),
    .issue_ready_o(issue_ready_o),
    .flush_i      (flush_i),
    .unit_start_o (unit_start_o),
    .unit_done_i  (unit_done_i),
    .unit_result_i(unit_result_i),
    .wb_valid_o   (wb_valid_o),
    .wb_data_o    (wb_data_o),
    .wb_ready_i   (wb_ready_i),
    .ex_ready_o   (ex_ready_o),
    .err_o        (err_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, expv);
  endtask

  task automatic sb_take(input int kind, input logic [31:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL sb_unexpected at %0t: got event %0d, expected none", $time, kind);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", kind, e.kind);
      if (kind == EV_WB && e.kind == EV_WB) check("sb_wb_data", data, e.data);
    end
  endtask

  // Monitor: every handshake, retire pulse and error pulse must match the next expected event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_valid_o && wb_ready_i && !flush_i) sb_take(EV_WB, wb_data_o);
      if (ex_ready_o) sb_take(EV_RET, 32'h0);
      if (err_o) sb_take(EV_ERR, 32'h0);
    end
  end

  // Random results on every unit and random done strobes on units other than u;
  // unit u strobes only when fire is set, carrying res.
  task automatic set_units(input int u, input bit fire, input logic [31:0] res);
    for (int k = 0; k < NU; k++) begin
      unit_result_i[k*DW +: DW] = $urandom;
      unit_done_i[k] = (k != u) ? 1'($urandom) : 1'b0;
    end
    if (u >= 0 && fire) begin
      unit_done_i[u] = 1'b1;
      unit_result_i[u*DW +: DW] = res;
    end
  endtask

  // One operation: unit u, done in EXEC cycle d, wb_ready held off r HOLD cycles,
  // flush in cycle f (-1 none), post idle cycles afterwards. Starts and ends at posedge+1.
  task automatic run_op(input int u, input int d, input int r, input int f,
                        input int post, input logic [31:0] res);
    bit legal;
    int exec_last, last_c, kind, hs, len;
    bit in_exec;
    legal = (u < NU);
    hs = 0;
    if (!legal) begin
      exec_last = -1; last_c = -1; kind = EV_ERR; d = -1;
    end else begin
      exec_last = (d < TO) ? d : TO - 1;
      if (f >= 0 && f <= exec_last) begin
        last_c = f; kind = EV_NONE;
      end else if (d >= TO) begin
        last_c = TO - 1; kind = EV_ERR;
      end else begin
        hs = d + 1 + r;
        if (f >= 0 && f <= hs) begin
          last_c = f; kind = EV_NONE;
        end else begin
          last_c = hs; kind = EV_WB;
        end
      end
    end
    if (kind == EV_WB) begin
      exp_q.push_back('{EV_WB, res});
      exp_q.push_back('{EV_RET, 32'h0});
    end else if (kind == EV_ERR) begin
      exp_q.push_back('{EV_ERR, 32'h0});
    end

    issue_valid_i = 1'b1;
    issue_unit_i  = 2'(u);
    flush_i       = 1'b0;
    wb_ready_i    = 1'($urandom);
    set_units(-1, 1'b0, 32'h0);
    @(negedge clk);
    check("issue_ready_idle", 32'(issue_ready_o), 32'd1);
    check("busy_idle", 32'(busy_o), 32'd0);
    @(posedge clk); #1;

    len = last_c + 1 + post;
    if (d + 1 > len) len = d + 1;
    for (int c = 0; c < len; c++) begin
      in_exec       = (c <= exec_last);
      flush_i       = (c == f);
      issue_valid_i = (c <= last_c);
      issue_unit_i  = 2'($urandom);
      if (!in_exec && c <= last_c) wb_ready_i = (c >= hs);
      else wb_ready_i = 1'($urandom);
      set_units(legal ? u : -1, c == d, res);
      @(negedge clk);
      if (c <= last_c) begin
        check("busy_op", 32'(busy_o), 32'd1);
        check("issue_ready_op", 32'(issue_ready_o), 32'd0);
        check("wb_valid_op", 32'(wb_valid_o), 32'(!in_exec));
        check("start_op", 32'(unit_start_o), (c == 0) ? (32'd1 << u) : 32'd0);
        check("err_op", 32'(err_o), 32'd0);
        check("ex_ready_op", 32'(ex_ready_o), 32'd0);
        if (!in_exec) check("wb_data_hold", wb_data_o, res);
      end else begin
        check("busy_after", 32'(busy_o), 32'd0);
        check("wb_valid_after", 32'(wb_valid_o), 32'd0);
        check("start_after", 32'(unit_start_o), 32'd0);
        check("issue_ready_after", 32'(issue_ready_o), 32'(!flush_i));
        check("err_after", 32'(err_o), 32'(c == last_c + 1 && kind == EV_ERR));
        check("ex_ready_after", 32'(ex_ready_o), 32'(c == last_c + 1 && kind == EV_WB));
      end
      @(posedge clk); #1;
    end
    flush_i       = 1'b0;
    issue_valid_i = 1'b0;
  endtask

  // Start an operation on unit 1, reset it three cycles later, release one cycle after.
  task automatic reset_mid(input int d);
    issue_valid_i = 1'b1;
    issue_unit_i  = 2'd1;
    flush_i       = 1'b0;
    wb_ready_i    = 1'b0;
    set_units(-1, 1'b0, 32'h0);
    @(posedge clk); #1;
    issue_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_units(1, c == d, 32'h1234_5678);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rst_mid_wb_data", wb_data_o, 32'd0);
    check("rst_mid_start", 32'(unit_start_o), 32'd0);
    check("rst_mid_pulses", {30'd0, ex_ready_o, err_o}, 32'd0);
    check("rst_mid_issue_ready", 32'(issue_ready_o), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int u, d, r, f, post;
    rst_n         = 1'b0;
    issue_valid_i = 1'b0;
    issue_unit_i  = '0;
    flush_i       = 1'b0;
    unit_done_i   = '0;
    unit_result_i = '0;
    wb_ready_i    = 1'b0;
    #2;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rst_wb_data", wb_data_o, 32'd0);
    check("rst_start", 32'(unit_start_o), 32'd0);
    check("rst_pulses", {30'd0, ex_ready_o, err_o}, 32'd0);
    check("rst_issue_ready", 32'(issue_ready_o), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(2, 3, 0, -1, 2, 32'hDEAD_BEEF);   // basic flow, first issue right after reset
    run_op(0, 0, 0, -1, 1, 32'h0000_0A0A);   // done in first EXEC cycle
    run_op(1, 2, 5, -1, 1, 32'h5A5A_0001);   // wb_ready held off 5 HOLD cycles
    run_op(1, 10, 0, -1, 2, 32'h0);          // timeout, late done ignored
    run_op(2, 7, 1, -1, 1, 32'hC0FF_EE00);   // done on the timeout cycle wins
    run_op(1, 2, 0, 2, 0, 32'h1111_2222);    // flush together with done
    run_op(0, 1, 0, -1, 0, 32'h3333_4444);   // accepted the very next cycle
    run_op(0, 1, 2, 4, 1, 32'h5555_6666);    // flush on the handshake cycle
    run_op(3, -1, 0, -1, 2, 32'h0);          // illegal unit
    run_op(2, 0, 0, -1, 0, 32'h7777_8888);   // back-to-back after illegal
    reset_mid(8);                            // reset during EXEC
    run_op(1, 1, 0, -1, 1, 32'h9999_AAAA);   // accepted in first cycle after reset
    reset_mid(0);                            // reset during HOLD
    run_op(2, 2, 1, -1, 1, 32'hBBBB_CCCC);

    for (int i = 0; i < 60; i++) begin
      u    = $urandom_range(0, 3);
      d    = $urandom_range(0, TO + 2);
      r    = $urandom_range(0, 4);
      f    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, d + r + 2) : -1;
      post = $urandom_range(0, 2);
      run_op(u, d, r, f, post, $urandom);
    end

    set_units(-1, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
